pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the five-stage pipeline.
- Drives stall and flush (bubble) controls into the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers and the PC.
- Causes handled: load-use hazards, taken branches resolved in EXE, data-memory wait states (with timeout) and debug halt requests (drain then hold).
- Keeps saturating stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for a five-stage pipeline
// Inputs: ID source regs/uses, EXE dest/load/branch, MEM dm_req/dm_ready, halt_req.
// Outputs: PC/IF-ID/ID-EXE/EXE-MEM stalls, IF-ID/ID-EXE flushes, MEM-WB bubble,
//          halt_ack, bus_err pulse, saturating stall_count/flush_count.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] exe_write_addr_o,
  input  logic              exe_DM_read,
  input  logic              exe_branch_taken,
  input  logic              dm_req,
  input  logic              dm_ready,
  input  logic              halt_req,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_exe_stall,
  output logic              id_exe_flush,
  output logic              exe_mem_stall,
  output logic              mem_wb_bubble,
  output logic              halt_ack,
  output logic              bus_err,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);
  localparam int WW = $clog2(MEM_TIMEOUT) + 1;
  localparam int DW = $clog2(DRAIN_CYC) + 1;
  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;
  state_t state, nstate;
  logic [WW-1:0] wait_cnt, nwait;
  logic [DW-1:0] drain_cnt, ndrain;
  logic memwait, loaduse;
  assign memwait = dm_req & ~dm_ready;
  assign loaduse = exe_DM_read & (exe_write_addr_o != '0) &
                   ((id_rs1_used & (id_rs1_addr == exe_write_addr_o)) |
                    (id_rs2_used & (id_rs2_addr == exe_write_addr_o)));
  always_comb begin
    {pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush,
     exe_mem_stall, mem_wb_bubble, halt_ack, bus_err} = '0;
    nstate = state;
    nwait = wait_cnt;
    ndrain = drain_cnt;
    case (state)
      RUN: begin
        if (memwait) begin
          {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall, mem_wb_bubble} = '1;
          nwait = WW'(1);
          nstate = MEM_WAIT;
        end else if (exe_branch_taken) begin
          {if_id_flush, id_exe_flush} = '1;
        end else if (loaduse) begin
          {pc_stall, if_id_stall, id_exe_flush} = '1;
        end else if (halt_req) begin
          ndrain = '0;
          nstate = DRAIN;
        end
      end
      MEM_WAIT: begin
        if (!memwait) begin
          nstate = RUN;
        end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
          {bus_err, mem_wb_bubble} = '1;
          nstate = RUN;
        end else begin
          {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall, mem_wb_bubble} = '1;
          nwait = wait_cnt + WW'(1);
        end
      end
      DRAIN: begin
        // a taken branch still redirects the PC so the drain resumes at the target
        pc_stall = ~exe_branch_taken;
        if_id_flush = exe_branch_taken;
        {if_id_stall, id_exe_flush} = '1;
        {id_exe_stall, exe_mem_stall, mem_wb_bubble} = {3{memwait}};
        if (!halt_req) nstate = RUN;
        else if (!memwait) begin
          if (drain_cnt == DW'(DRAIN_CYC - 1)) nstate = HALTED;
          else ndrain = drain_cnt + DW'(1);
        end
      end
      HALTED: begin
        {pc_stall, if_id_stall, id_exe_flush, halt_ack} = '1;
        if (!halt_req) nstate = RUN;
      end
      default: nstate = RUN;
    endcase
    if (rst)
      {pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush,
       exe_mem_stall, mem_wb_bubble, halt_ack, bus_err} = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wait_cnt <= '0;
      drain_cnt <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= nstate;
      wait_cnt <= nwait;
      drain_cnt <= ndrain;
      if (pc_stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      if ((if_id_flush || id_exe_flush) && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl (CNT_W=4)
module tb_pipe_hazard_ctrl;
  localparam logic [8:0] PS = 9'h100, IS = 9'h080, IF = 9'h040, ES = 9'h020, EF = 9'h010,
                         MS = 9'h008, WB = 9'h004, HA = 9'h002, BE = 9'h001;
  localparam logic [8:0] MEMW = PS | IS | ES | MS | WB;
  localparam logic [8:0] LU = PS | IS | EF;
  localparam logic [8:0] BR = IF | EF;
  localparam logic [8:0] DR = PS | IS | EF;
  typedef struct packed {logic r; logic [8:0] e;} exp_t;
  logic clk = 1'b0, rst;
  logic [4:0] rs1, rs2, wa;
  logic used1, used2, dmr, br, dm_req, dm_ready, halt_req;
  logic pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush;
  logic exe_mem_stall, mem_wb_bubble, halt_ack, bus_err;
  logic [3:0] stall_count, flush_count, m_sc, m_fc;
  logic [8:0] act;
  exp_t q[$];
  exp_t x;
  int checks = 0, failures = 0;
  string cur = "init";
  pipe_hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(16), .DRAIN_CYC(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_rs1_addr(rs1), .id_rs2_addr(rs2),
    .id_rs1_used(used1), .id_rs2_used(used2), .exe_write_addr_o(wa),
    .exe_DM_read(dmr), .exe_branch_taken(br), .dm_req(dm_req), .dm_ready(dm_ready),
    .halt_req(halt_req), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .id_exe_stall(id_exe_stall), .id_exe_flush(id_exe_flush),
    .exe_mem_stall(exe_mem_stall), .mem_wb_bubble(mem_wb_bubble), .halt_ack(halt_ack),
    .bus_err(bus_err), .stall_count(stall_count), .flush_count(flush_count));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      x = q.pop_front();
      act = {pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush,
             exe_mem_stall, mem_wb_bubble, halt_ack, bus_err};
      checks++;
      if (act !== x.e) begin
        failures++;
        $display("FAIL %s ctl: got %b want %b", cur, act, x.e);
      end
      checks++;
      if (stall_count !== m_sc) begin
        failures++;
        $display("FAIL %s stall_count: got %0d want %0d", cur, stall_count, m_sc);
      end
      checks++;
      if (flush_count !== m_fc) begin
        failures++;
        $display("FAIL %s flush_count: got %0d want %0d", cur, flush_count, m_fc);
      end
      if (x.r) begin
        m_sc = '0;
        m_fc = '0;
      end else begin
        if (x.e[8] && m_sc != 4'hf) m_sc = m_sc + 4'd1;
        if ((x.e[6] || x.e[4]) && m_fc != 4'hf) m_fc = m_fc + 4'd1;
      end
    end
  end
  task automatic tick(input logic [8:0] e);
    q.push_back({rst, e});
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {rs1, rs2, wa} = '0;
    {used1, used2, dmr, br, dm_req, dm_ready, halt_req} = '0;
  endtask
  task automatic test_reset();
    cur = "reset";
    rst = 1'b1;
    dmr = 1'b1; wa = 5'd3; rs1 = 5'd3; used1 = 1'b1; dm_req = 1'b1; halt_req = 1'b1;
    tick(9'h0);
    rst = 1'b0;
    clr();
    tick(9'h0);
    tick(9'h0);
  endtask
  task automatic test_loaduse();
    cur = "loaduse";
    dmr = 1'b1; wa = 5'd5; rs2 = 5'd5; used2 = 1'b1;
    tick(LU);
    clr();
    tick(9'h0);
    dmr = 1'b1; wa = 5'd0; rs2 = 5'd0; used2 = 1'b1;
    tick(9'h0);
    clr();
    dmr = 1'b1; wa = 5'd7; rs1 = 5'd7; used1 = 1'b1;
    tick(LU);
    used1 = 1'b0;
    tick(9'h0);
    clr();
  endtask
  task automatic test_branch();
    cur = "branch";
    dmr = 1'b1; wa = 5'd9; rs1 = 5'd9; used1 = 1'b1; br = 1'b1;
    tick(BR);
    clr();
    tick(9'h0);
  endtask
  task automatic test_memwait();
    cur = "memwait";
    dm_req = 1'b1;
    repeat (4) tick(MEMW);
    dm_ready = 1'b1;
    tick(9'h0);
    clr();
    br = 1'b1;
    tick(BR);
    clr();
  endtask
  task automatic test_timeout();
    cur = "timeout";
    dm_req = 1'b1;
    repeat (15) tick(MEMW);
    tick(WB | BE);
    clr();
    tick(9'h0);
    br = 1'b1;
    tick(BR);
    clr();
  endtask
  task automatic test_halt();
    cur = "halt";
    halt_req = 1'b1;
    tick(9'h0);
    repeat (3) tick(DR);
    repeat (2) tick(DR | HA);
    halt_req = 1'b0;
    tick(DR | HA);
    tick(9'h0);
  endtask
  task automatic test_drain_cases();
    cur = "drain_memwait";
    halt_req = 1'b1;
    tick(9'h0);
    dm_req = 1'b1;
    repeat (2) tick(DR | ES | MS | WB);
    dm_req = 1'b0;
    repeat (3) tick(DR);
    tick(DR | HA);
    clr();
    tick(DR | HA);
    cur = "drain_abandon";
    halt_req = 1'b1;
    tick(9'h0);
    tick(DR);
    halt_req = 1'b0;
    tick(DR);
    tick(9'h0);
    cur = "drain_branch";
    halt_req = 1'b1;
    tick(9'h0);
    br = 1'b1;
    tick(IS | IF | EF);
    br = 1'b0;
    tick(DR);
    tick(DR);
    tick(DR | HA);
    clr();
    tick(DR | HA);
    tick(9'h0);
  endtask
  task automatic test_saturation();
    cur = "saturation";
    dmr = 1'b1; wa = 5'd4; rs1 = 5'd4; used1 = 1'b1;
    repeat (20) tick(LU);
    clr();
    tick(9'h0);
  endtask
  task automatic test_reset_mid();
    cur = "reset_mid_drain";
    halt_req = 1'b1;
    tick(9'h0);
    tick(DR);
    rst = 1'b1;
    tick(9'h0);
    rst = 1'b0;
    halt_req = 1'b0;
    tick(9'h0);
    cur = "reset_mid_wait";
    dm_req = 1'b1;
    repeat (3) tick(MEMW);
    rst = 1'b1;
    tick(9'h0);
    rst = 1'b0;
    clr();
    tick(9'h0);
    tick(9'h0);
  endtask
  initial begin
    m_sc = '0;
    m_fc = '0;
    rst = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_loaduse();
    test_branch();
    test_memwait();
    test_timeout();
    test_halt();
    test_drain_cases();
    test_saturation();
    test_reset_mid();
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_queue: got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
